// File: rtl/fifo_rd_pkg.sv
// Shared sizing for the sync_fifo read adapter: output buffer depth, pointer
// width, the issue threshold and the circular pointer increment.
package fifo_rd_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int PTR_WID   = 2;

    // Highest buf_cnt + inflight that still allows a new read to be issued.
    localparam logic [PTR_WID:0] ISSUE_MAX = (PTR_WID+1)'(BUF_DEPTH - 1);

    function automatic logic [PTR_WID-1:0] ptr_inc(input logic [PTR_WID-1:0] p);
        return (p == PTR_WID'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Three-entry circular output buffer: push from the FIFO response, pop on a
// valid/ready handshake, with an occupancy count.
module fifo_rd_buf
    import fifo_rd_pkg::*;
#(
    parameter int BITWID = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [BITWID-1:0]  i_data,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [BITWID-1:0]  o_data,
    output logic               o_pop,
    output logic [PTR_WID-1:0] o_cnt
);

    logic [BITWID-1:0]  r_mem [BUF_DEPTH];
    logic [PTR_WID-1:0] r_wptr;
    logic [PTR_WID-1:0] r_rptr;
    logic [PTR_WID-1:0] r_cnt;
    logic               w_pop;

    assign o_valid = (r_cnt != '0);
    assign o_data  = r_mem[r_rptr];
    assign w_pop   = o_valid & i_ready;
    assign o_pop   = w_pop;
    assign o_cnt   = r_cnt;

    // Storage is cleared too so that the stream word reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_adapter.sv
// Drains sync_fifo's one-cycle-latency read port into a valid/ready stream,
// tracking the outstanding read, response errors and delivered-word count.
module fifo_rd_adapter
    import fifo_rd_pkg::*;
#(
    parameter int BITWID = 5,
    parameter int CNTWID = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [BITWID-1:0]  fifo_rd_data,
    input  logic               fifo_rd_data_vld,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [BITWID-1:0]  m_data,
    output logic [PTR_WID-1:0] buf_cnt,
    output logic [CNTWID-1:0]  rd_cnt,
    output logic               err_unexp
);

    logic              r_inflight;
    logic              r_err;
    logic [CNTWID-1:0] r_rd_cnt;
    logic              w_push;
    logic              w_pop;
    logic [PTR_WID:0]  w_level;

    // Issue never looks at m_ready; the level check alone keeps the buffer from
    // overflowing, and rst_n holds the read strobe low while reset is asserted.
    assign w_level    = {1'b0, buf_cnt} + {{PTR_WID{1'b0}}, r_inflight};
    assign fifo_rd_en = rst_n & en & ~fifo_empty & (w_level <= ISSUE_MAX);
    assign w_push     = r_inflight & fifo_rd_data_vld;
    assign rd_cnt     = r_rd_cnt;
    assign err_unexp  = r_err;

    fifo_rd_buf #(
        .BITWID (BITWID)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (fifo_rd_data),
        .i_ready (m_ready),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_pop   (w_pop),
        .o_cnt   (buf_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
            r_rd_cnt   <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (r_inflight != fifo_rd_data_vld) begin
                r_err <= 1'b1;
            end
            if (w_pop) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: a behavioural 8-deep sync FIFO plus an in-order
// scoreboard, directed scenarios and a randomized traffic phase.
module tb_fifo_rd_adapter;

    localparam int BW    = 5;
    localparam int CW    = 4;
    localparam int FDEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [BW-1:0] fifo_rd_data;
    logic          fifo_rd_data_vld;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [BW-1:0] m_data;
    logic [1:0]    buf_cnt;
    logic [CW-1:0] rd_cnt;
    logic          err_unexp;

    logic          wr_en = 1'b0;
    logic [BW-1:0] wr_data = '0;
    logic          force_vld = 1'b0;
    logic [BW-1:0] r_fdata = '0;
    logic          r_fvld = 1'b0;
    int            fnum = 0;
    logic [BW-1:0] fq [$];
    logic [BW-1:0] exp_q [$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rden = 0, nvld = 0, npop = 0;
    int first_rden = -1, last_rden = -1, first_vld = -1, first_pop = -1, last_pop = -1;
    logic [CW-1:0] mcnt = '0;
    logic          hold = 1'b0;
    logic [BW-1:0] hold_data = '0;

    always #5 clk = ~clk;

    assign fifo_empty       = (fnum == 0);
    assign fifo_rd_data     = r_fdata;
    assign fifo_rd_data_vld = r_fvld | force_vld;

    fifo_rd_adapter #(
        .BITWID (BW),
        .CNTWID (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .fifo_empty       (fifo_empty),
        .fifo_rd_en       (fifo_rd_en),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_rd_data_vld (fifo_rd_data_vld),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .buf_cnt          (buf_cnt),
        .rd_cnt           (rd_cnt),
        .err_unexp        (err_unexp)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Behavioural sync FIFO: one-cycle read latency, every accepted write is
    // also queued on the scoreboard in arrival order.
    always @(posedge clk) begin
        int n;
        cyc <= cyc + 1;
        if (!rst_n) begin
            fq.delete();
            exp_q.delete();
            r_fvld  <= 1'b0;
            r_fdata <= '0;
        end else begin
            if (fifo_rd_en && fq.size() > 0) begin
                r_fdata <= fq.pop_front();
                r_fvld  <= 1'b1;
            end else begin
                r_fvld <= 1'b0;
            end
            if (wr_en && fq.size() < FDEPTH) begin
                fq.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
        end
        n = fq.size();
        fnum <= n;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            mcnt = '0;
            hold = 1'b0;
        end else begin
            chk("rd_cnt", 32'(rd_cnt), 32'(mcnt));
            if (fifo_rd_en) begin
                rden++;
                chk("rd_en_while_empty", 32'(fifo_empty), 0);
                if (first_rden < 0) first_rden = cyc;
                last_rden = cyc;
            end
            if (fifo_rd_data_vld) nvld++;
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (hold) begin
                chk("hold_valid", 32'(m_valid), 1);
                chk("hold_data", 32'(m_data), 32'(hold_data));
            end
            if (m_valid && m_ready) begin
                chk("word_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("data_order", 32'(m_data), 32'(exp_q.pop_front()));
                mcnt = mcnt + 1'b1;
                npop++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            hold      = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [BW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic clr_stats();
        rden = 0; nvld = 0; npop = 0;
        first_rden = -1; last_rden = -1; first_vld = -1; first_pop = -1; last_pop = -1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < budget) begin
            tick(1);
            k++;
        end
        chk("drain_in_budget", 32'(exp_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_data"}, 32'(m_data), 0);
        chk({tag, "_buf_cnt"}, 32'(buf_cnt), 0);
        chk({tag, "_rd_cnt"}, 32'(rd_cnt), 0);
        chk({tag, "_err"}, 32'(err_unexp), 0);
    endtask

    initial begin
        logic [BW-1:0] basic [4];
        logic [BW-1:0] conc [4];
        int k;
        basic = '{5'd3, 5'd5, 5'd16, 5'd28};
        conc  = '{5'd17, 5'd4, 5'd25, 5'd22};

        en = 1'b1;
        wr_en = 1'b0;
        tick(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        en = 1'b0;
        tick(1);

        // Basic order and first-word latency
        foreach (basic[i]) wr(basic[i]);
        clr_stats();
        en = 1'b1;
        m_ready = 1'b1;
        tick(10);
        chk("basic_rd_en_pulses", 32'(rden), 4);
        chk("basic_rd_en_span", 32'(last_rden - first_rden), 3);
        chk("basic_latency", 32'(first_vld - first_rden), 2);
        chk("basic_pops", 32'(npop), 4);
        chk("basic_pop_span", 32'(last_pop - first_pop), 3);
        chk("basic_rd_cnt", 32'(rd_cnt), 4);

        // Backpressure: three reads fill the buffer, then restart with no gaps
        en = 1'b0;
        m_ready = 1'b0;
        repeat (8) wr(BW'($urandom));
        clr_stats();
        en = 1'b1;
        tick(10);
        chk("bp_rd_en_pulses", 32'(rden), 3);
        chk("bp_buf_cnt", 32'(buf_cnt), 3);
        chk("bp_fifo_num", 32'(fnum), 5);
        clr_stats();
        m_ready = 1'b1;
        drain(40);
        chk("bp_pops", 32'(npop), 8);
        chk("bp_pop_span", 32'(last_pop - first_pop), 7);

        // Concurrent write while draining
        foreach (conc[i]) wr(conc[i]);
        drain(20);

        // Enable gating with a read outstanding
        en = 1'b0;
        repeat (6) wr(BW'($urandom));
        clr_stats();
        en = 1'b1;
        k = 0;
        @(negedge clk);
        while (!fifo_rd_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("gate_saw_rd_en", 32'(fifo_rd_en), 1);
        @(posedge clk);
        #1;
        en = 1'b0;
        nvld = 0;
        rden = 0;
        tick(6);
        chk("gate_one_push", 32'(nvld), 1);
        chk("gate_no_reads", 32'(rden), 0);
        chk("gate_buf_empty", 32'(buf_cnt), 0);
        chk("gate_valid_low", 32'(m_valid), 0);
        chk("gate_fifo_left", 32'(fnum), 5);
        en = 1'b1;
        drain(30);

        // Unexpected response with nothing in flight
        en = 1'b0;
        tick(2);
        chk("err_before", 32'(err_unexp), 0);
        force_vld = 1'b1;
        tick(1);
        force_vld = 1'b0;
        chk("err_set", 32'(err_unexp), 1);
        chk("err_buf_cnt", 32'(buf_cnt), 0);
        tick(3);
        chk("err_sticky", 32'(err_unexp), 1);

        // Asynchronous reset in the middle of a burst
        repeat (6) wr(BW'($urandom));
        en = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Counter wrap at CNTWID=4
        clr_stats();
        en = 1'b1;
        m_ready = 1'b1;
        repeat (17) wr(BW'($urandom));
        drain(30);
        chk("wrap_pops", 32'(npop), 17);
        chk("wrap_rd_cnt", 32'(rd_cnt), 1);

        // Randomized traffic with random backpressure and enable
        for (int i = 0; i < 400; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            en      = ($urandom_range(0, 7) != 0);
            wr_en   = (fnum < FDEPTH - 1) && ($urandom_range(0, 1) == 1);
            wr_data = BW'($urandom);
            tick(1);
        end
        wr_en = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;
        drain(60);
        chk("rand_no_err", 32'(err_unexp), 0);
        chk("rand_buf_empty", 32'(buf_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
